// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: one partial product per clock, unsigned or
// signed (magnitude multiply then conditional negate), with start/done handshake.
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     inputA,
    input  logic [WIDTH-1:0]     inputB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]         r_state;
    logic               r_mode;
    logic               r_neg;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_count;
    logic               r_done;
    logic [2*WIDTH-1:0] r_product;
    logic               r_overflow;

    logic               w_accept;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mag;
    logic [2*WIDTH-1:0] w_result;
    logic [WIDTH:0]     w_top;
    logic               w_ovf;

    // FIN accepts a new request too, so back-to-back operation has no idle bubble.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_FIN));

    // Negating -2^(W-1) yields itself, which read as unsigned is the correct magnitude.
    assign w_a_mag = (mode && inputA[WIDTH-1]) ? -inputA : inputA;
    assign w_b_mag = (mode && inputB[WIDTH-1]) ? -inputB : inputB;

    assign w_sum    = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_mag    = {r_acc, r_mplier};
    assign w_result = r_neg ? -w_mag : w_mag;

    // Signed fit needs the upper half plus the narrow sign bit to be a pure sign extension.
    assign w_top = w_result[2*WIDTH-1:WIDTH-1];
    assign w_ovf = r_mode ? !((&w_top) || !(|w_top))
                          : (|w_result[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mode     <= 1'b0;
            r_neg      <= 1'b0;
            r_mcand    <= '0;
            r_acc      <= '0;
            r_mplier   <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_product  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_RUN: begin
                    r_acc    <= w_sum[WIDTH:1];
                    r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
                    r_count  <= r_count + CW'(1);
                    if (r_count == LAST_ITER) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_product  <= w_result;
                    r_overflow <= w_ovf;
                    r_done     <= 1'b1;
                    r_state    <= S_IDLE;
                end
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A later assignment wins, so a load in FIN overrides the return to IDLE.
            if (w_accept) begin
                r_state  <= S_RUN;
                r_mode   <= mode;
                r_neg    <= mode && (inputA[WIDTH-1] ^ inputB[WIDTH-1]);
                r_mcand  <= w_a_mag;
                r_mplier <= w_b_mag;
                r_acc    <= '0;
                r_count  <= '0;
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign product  = r_product;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed-vector bench for seq_multiplier at WIDTH=16, plus WIDTH=4/8/32 instances
// sharing the same start/mode/operand stimulus for the width sweep.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;

    logic        busy16, done16, ovf16;
    logic [31:0] prod16;
    logic        busy4, done4, ovf4;
    logic [7:0]  prod4;
    logic        busy8, done8, ovf8;
    logic [15:0] prod8;
    logic        busy32, done32, ovf32;
    logic [63:0] prod32;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        logic        ov;
    } vec16_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        m;
        logic [7:0]  p4;
        logic        o4;
        logic [15:0] p8;
        logic        o8;
        logic [63:0] p32;
        logic        o32;
    } vecw_t;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .inputA(op_a[15:0]), .inputB(op_b[15:0]),
        .busy(busy16), .done(done16), .product(prod16), .overflow(ovf16)
    );

    seq_multiplier #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .inputA(op_a[3:0]), .inputB(op_b[3:0]),
        .busy(busy4), .done(done4), .product(prod4), .overflow(ovf4)
    );

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .inputA(op_a[7:0]), .inputB(op_b[7:0]),
        .busy(busy8), .done(done8), .product(prod8), .overflow(ovf8)
    );

    seq_multiplier #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .inputA(op_a), .inputB(op_b),
        .busy(busy32), .done(done32), .product(prod32), .overflow(ovf32)
    );

    // Drives start for exactly one rising edge; returns at the negedge after that edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic m);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges until done16 is seen, bounded so a dead DUT reports lat=64.
    task automatic wait_done16(inout int lat);
        while (done16 !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy16 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy16); end
        total++; if (done16 !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done16); end
        total++; if (prod16 !== 32'h0) begin bad++; $display("FAIL reset_product: got %h expected 00000000", prod16); end
        total++; if (ovf16 !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b expected 0", ovf16); end
        total++; if ({busy4, busy8, busy32} !== 3'b000) begin bad++; $display("FAIL reset_busy_widths: got %b expected 000", {busy4, busy8, busy32}); end
        rst_n = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_unsigned();
        vec16_t v [4];
        int lat;
        int nb;
        launch(32'h0006, 32'h000E, 1'b0);
        lat = 0;
        nb = 0;
        while (done16 !== 1'b1 && lat < 64) begin
            if (busy16 === 1'b1) nb++;
            @(negedge clk);
            lat++;
        end
        $display("txn unsigned 0006*000e product=%h ovf=%b lat=%0d busy_cycles=%0d", prod16, ovf16, lat, nb);
        total++; if (lat != 17) begin bad++; $display("FAIL u6x14_latency: got %0d expected 17", lat); end
        total++; if (nb != 17) begin bad++; $display("FAIL u6x14_busy_cycles: got %0d expected 17", nb); end
        total++; if (prod16 !== 32'h00000054) begin bad++; $display("FAIL u6x14_product: got %h expected 00000054", prod16); end
        total++; if (ovf16 !== 1'b0) begin bad++; $display("FAIL u6x14_overflow: got %b expected 0", ovf16); end
        total++; if (busy16 !== 1'b0) begin bad++; $display("FAIL u6x14_busy_at_done: got %b expected 0", busy16); end
        @(negedge clk);
        total++; if (done16 !== 1'b0) begin bad++; $display("FAIL u6x14_done_pulse: got %b expected 0", done16); end

        v[0] = '{a: 16'hFFFF, b: 16'hFFFF, p: 32'hFFFE0001, ov: 1'b1};
        v[1] = '{a: 16'h00FF, b: 16'h0101, p: 32'h0000FFFF, ov: 1'b0};
        v[2] = '{a: 16'h0100, b: 16'h0100, p: 32'h00010000, ov: 1'b1};
        v[3] = '{a: 16'h0000, b: 16'h1234, p: 32'h00000000, ov: 1'b0};
        for (int i = 0; i < 4; i++) begin
            launch({16'h0, v[i].a}, {16'h0, v[i].b}, 1'b0);
            lat = 0;
            wait_done16(lat);
            $display("txn unsigned %h*%h product=%h ovf=%b lat=%0d", v[i].a, v[i].b, prod16, ovf16, lat);
            total++; if (lat != 17) begin bad++; $display("FAIL unsigned_latency[%0d]: got %0d expected 17", i, lat); end
            total++; if (prod16 !== v[i].p) begin bad++; $display("FAIL unsigned_product[%0d]: got %h expected %h", i, prod16, v[i].p); end
            total++; if (ovf16 !== v[i].ov) begin bad++; $display("FAIL unsigned_overflow[%0d]: got %b expected %b", i, ovf16, v[i].ov); end
        end
    endtask

    task automatic test_signed();
        vec16_t v [5];
        int lat;
        v[0] = '{a: 16'hFFFF, b: 16'hFFFF, p: 32'h00000001, ov: 1'b0};
        v[1] = '{a: 16'h8000, b: 16'h8000, p: 32'h40000000, ov: 1'b1};
        v[2] = '{a: 16'hFFFA, b: 16'h0007, p: 32'hFFFFFFD6, ov: 1'b0};
        v[3] = '{a: 16'h7FFF, b: 16'h0002, p: 32'h0000FFFE, ov: 1'b1};
        v[4] = '{a: 16'h8000, b: 16'hFFFF, p: 32'h00008000, ov: 1'b1};
        for (int i = 0; i < 5; i++) begin
            launch({16'h0, v[i].a}, {16'h0, v[i].b}, 1'b1);
            lat = 0;
            wait_done16(lat);
            $display("txn signed %h*%h product=%h ovf=%b lat=%0d", v[i].a, v[i].b, prod16, ovf16, lat);
            total++; if (lat != 17) begin bad++; $display("FAIL signed_latency[%0d]: got %0d expected 17", i, lat); end
            total++; if (prod16 !== v[i].p) begin bad++; $display("FAIL signed_product[%0d]: got %h expected %h", i, prod16, v[i].p); end
            total++; if (ovf16 !== v[i].ov) begin bad++; $display("FAIL signed_overflow[%0d]: got %b expected %b", i, ovf16, v[i].ov); end
        end
    endtask

    task automatic test_ignored_start();
        int lat;
        int extra;
        launch(32'h0064, 32'h00C8, 1'b0);
        repeat (4) @(negedge clk);
        op_a  = 32'h0009;
        op_b  = 32'h0009;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 5;
        wait_done16(lat);
        $display("txn ignored_start 0064*00c8 product=%h ovf=%b lat=%0d", prod16, ovf16, lat);
        total++; if (lat != 17) begin bad++; $display("FAIL ignored_start_latency: got %0d expected 17", lat); end
        total++; if (prod16 !== 32'h00004E20) begin bad++; $display("FAIL ignored_start_product: got %h expected 00004e20", prod16); end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done16 === 1'b1) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL ignored_start_extra_done: got %0d expected 0", extra); end
        total++; if (busy16 !== 1'b0) begin bad++; $display("FAIL ignored_start_idle: got %b expected 0", busy16); end
    endtask

    task automatic test_back_to_back();
        int lat;
        launch(32'h0012, 32'h0034, 1'b0);
        repeat (16) @(negedge clk);
        total++; if (busy16 !== 1'b1 || done16 !== 1'b0) begin bad++; $display("FAIL b2b_fin_state: got busy=%b done=%b expected busy=1 done=0", busy16, done16); end
        op_a  = 32'h0003;
        op_b  = 32'h0005;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        $display("txn b2b first 0012*0034 product=%h ovf=%b", prod16, ovf16);
        total++; if (done16 !== 1'b1) begin bad++; $display("FAIL b2b_first_done: got %b expected 1", done16); end
        total++; if (prod16 !== 32'h000003A8) begin bad++; $display("FAIL b2b_first_product: got %h expected 000003a8", prod16); end
        total++; if (busy16 !== 1'b1) begin bad++; $display("FAIL b2b_no_bubble: got %b expected 1", busy16); end
        repeat (8) @(negedge clk);
        total++; if (prod16 !== 32'h000003A8) begin bad++; $display("FAIL b2b_product_held: got %h expected 000003a8", prod16); end
        lat = 8;
        wait_done16(lat);
        $display("txn b2b second 0003*0005 product=%h ovf=%b lat=%0d", prod16, ovf16, lat);
        total++; if (lat != 17) begin bad++; $display("FAIL b2b_second_spacing: got %0d expected 17", lat); end
        total++; if (prod16 !== 32'h0000000F) begin bad++; $display("FAIL b2b_second_product: got %h expected 0000000f", prod16); end
        total++; if (ovf16 !== 1'b0) begin bad++; $display("FAIL b2b_second_overflow: got %b expected 0", ovf16); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int stray;
        launch(32'h0100, 32'h0100, 1'b0);
        lat = 0;
        wait_done16(lat);
        total++; if (ovf16 !== 1'b1) begin bad++; $display("FAIL pre_abort_overflow: got %b expected 1", ovf16); end
        launch(32'hFFFF, 32'hFFFF, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        $display("txn abort mid-run busy=%b done=%b product=%h ovf=%b", busy16, done16, prod16, ovf16);
        total++; if (busy16 !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", busy16); end
        total++; if (done16 !== 1'b0) begin bad++; $display("FAIL abort_done: got %b expected 0", done16); end
        total++; if (prod16 !== 32'h0) begin bad++; $display("FAIL abort_product: got %h expected 00000000", prod16); end
        total++; if (ovf16 !== 1'b0) begin bad++; $display("FAIL abort_overflow: got %b expected 0", ovf16); end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (24) begin
            @(negedge clk);
            if (done16 === 1'b1) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL abort_no_done: got %0d expected 0", stray); end
        launch(32'h1234, 32'h0010, 1'b0);
        lat = 0;
        wait_done16(lat);
        $display("txn after_abort 1234*0010 product=%h ovf=%b lat=%0d", prod16, ovf16, lat);
        total++; if (lat != 17) begin bad++; $display("FAIL after_abort_latency: got %0d expected 17", lat); end
        total++; if (prod16 !== 32'h00012340) begin bad++; $display("FAIL after_abort_product: got %h expected 00012340", prod16); end
        total++; if (ovf16 !== 1'b1) begin bad++; $display("FAIL after_abort_overflow: got %b expected 1", ovf16); end
    endtask

    task automatic test_width_sweep();
        vecw_t v [3];
        int l4, l8, l32;
        logic [7:0]  p4;
        logic [15:0] p8;
        logic [63:0] p32;
        logic o4, o8, o32;
        v[0] = '{a: 32'hFFFFFFFF, b: 32'h00000002, m: 1'b0,
                 p4: 8'h1E, o4: 1'b1, p8: 16'h01FE, o8: 1'b1, p32: 64'h00000001FFFFFFFE, o32: 1'b1};
        v[1] = '{a: 32'hFFFFFFF8, b: 32'h00000008, m: 1'b1,
                 p4: 8'h40, o4: 1'b1, p8: 16'hFFC0, o8: 1'b0, p32: 64'hFFFFFFFFFFFFFFC0, o32: 1'b0};
        v[2] = '{a: 32'h80000007, b: 32'hFFFFFF89, m: 1'b1,
                 p4: 8'hCF, o4: 1'b1, p8: 16'hFCBF, o8: 1'b1, p32: 64'h0000003B7FFFFCBF, o32: 1'b1};
        repeat (40) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            launch(v[i].a, v[i].b, v[i].m);
            l4 = -1; l8 = -1; l32 = -1;
            p4 = '0; p8 = '0; p32 = '0;
            o4 = 1'b0; o8 = 1'b0; o32 = 1'b0;
            for (int n = 0; n <= 40; n++) begin
                if (done4 === 1'b1 && l4 < 0) begin l4 = n; p4 = prod4; o4 = ovf4; end
                if (done8 === 1'b1 && l8 < 0) begin l8 = n; p8 = prod8; o8 = ovf8; end
                if (done32 === 1'b1 && l32 < 0) begin l32 = n; p32 = prod32; o32 = ovf32; end
                @(negedge clk);
            end
            $display("txn sweep[%0d] w4=%h/%b@%0d w8=%h/%b@%0d w32=%h/%b@%0d", i, p4, o4, l4, p8, o8, l8, p32, o32, l32);
            total++; if (l4 != 5) begin bad++; $display("FAIL w4_latency[%0d]: got %0d expected 5", i, l4); end
            total++; if (p4 !== v[i].p4 || o4 !== v[i].o4) begin bad++; $display("FAIL w4_result[%0d]: got %h/%b expected %h/%b", i, p4, o4, v[i].p4, v[i].o4); end
            total++; if (l8 != 9) begin bad++; $display("FAIL w8_latency[%0d]: got %0d expected 9", i, l8); end
            total++; if (p8 !== v[i].p8 || o8 !== v[i].o8) begin bad++; $display("FAIL w8_result[%0d]: got %h/%b expected %h/%b", i, p8, o8, v[i].p8, v[i].o8); end
            total++; if (l32 != 33) begin bad++; $display("FAIL w32_latency[%0d]: got %0d expected 33", i, l32); end
            total++; if (p32 !== v[i].p32 || o32 !== v[i].o32) begin bad++; $display("FAIL w32_result[%0d]: got %h/%b expected %h/%b", i, p32, o32, v[i].p32, v[i].o32); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        test_width_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
